fpmul_apb_sequencer: RTL
========================

// Module: fpmul_apb_sequencer
// PURPOSE
// - APB master sequencer sharing one IEEE-754 multiplier APB slave between two requesters.
// - Round-robin arbitrates requests, then runs three APB transfers per request:
//   write A, write B, read product.
// - Returns the product with the requester ID.
// - Sits between on-chip requesters (CPU-side glue, DMA) and one psel port of amba_apb_bus.
// PARAMETERS
// - BASE_ADDR       32'h0000_0000  slave base; A @+0x0, B @+0x4, product @+0x8
// - TIMEOUT_CYCLES  16             max pready-low ACCESS cycles (used only with FPMUL_SEQ_TIMEOUT_EN)
// PORTS
// - clk         in   1   clock; APB domain clock (clk_div4 at top level)
// - rst         in   1   synchronous, active-high reset
// - req0_valid  in   1   requester 0 operands valid
// - req0_ready  out  1   requester 0 accepted (handshake = valid & ready)
// - req0_a      in   32  requester 0 operand A (IEEE-754 single)
// - req0_b      in   32  requester 0 operand B
// - req1_valid  in   1   requester 1 operands valid
// - req1_ready  out  1   requester 1 accepted
// - req1_a      in   32  requester 1 operand A
// - req1_b      in   32  requester 1 operand B
// - rsp_valid   out  1   product valid
// - rsp_ready   in   1   consumer takes product
// - rsp_id      out  1   requester ID of product
// - rsp_data    out  32  product read from slave
// - rsp_err     out  1   transfer timed out
// - busy        out  1   FSM not in IDLE
// - paddr       out  32  APB address
// - psel        out  1   APB select
// - penable     out  1   APB enable
// - pwrite      out  1   APB direction (1 = write)
// - pwdata      out  32  APB write data
// - pready      in   1   APB slave ready
// - prdata      in   32  APB read data
// BEHAVIOUR
// - Reset values: all outputs 0; FSM=IDLE; rr_last=1 (req0 wins first tie); xfer=0.
// - FSM states: IDLE, SETUP, ACCESS, RESP.
// - IDLE:
//   - reqN_ready is high only in IDLE, combinationally for the granted N.
//   - Grant goes to the sole valid requester. If both are valid, grant goes to
//     ~rr_last.
//   - On handshake: latch a, b, id; rr_last <= id; xfer <= 0; go to SETUP.
// - SETUP:
//   - psel=1, penable=0. paddr = BASE_ADDR + {0x0, 0x4, 0x8}[xfer].
//   - pwrite=1 for xfer 0/1, pwrite=0 for xfer 2.
//   - pwdata = A (xfer 0), B (xfer 1), 0 (xfer 2).
//   - Next state: ACCESS.
// - ACCESS:
//   - psel=1, penable=1; paddr, pwrite, pwdata held stable.
//   - If pready=0: stay in ACCESS.
//   - If pready=1 and xfer<2: xfer++, go to SETUP (no idle cycle between transfers).
//   - If pready=1 and xfer==2: capture prdata into rsp_data, go to RESP.
// - RESP:
//   - psel=penable=0; rsp_valid=1; rsp_id and rsp_data held stable.
//   - On rsp_valid & rsp_ready: go to IDLE; rsp_valid falls next cycle.
//   - A new request is accepted no earlier than the cycle after leaving RESP.
// - Latency, zero-wait slave: handshake at cycle T; SETUP-A at T+1; ACCESS-R at T+6;
//   rsp_valid at T+7. Each wait state adds 1 cycle.
// - Operands are latched at handshake. Input changes after that have no effect.
// - Simultaneous valid in RESP: ignored; ready stays low; requesters keep valid asserted.
// - Back-to-back contention alternates 0,1,0,1. A lone requester is served every time.
// - Reset mid-operation: next edge returns all outputs to reset values.
//   - APB transfer is abandoned; in-flight request and product are discarded.
//   - rr_last returns to 1.
// CONFIGURATION
// - FPMUL_SEQ_TIMEOUT_EN defined:
//   - A counter increments each ACCESS cycle with pready=0; it clears on SETUP.
//   - When it reaches TIMEOUT_CYCLES: next cycle psel=penable=0, go to RESP with
//     rsp_err=1 and rsp_data=0; remaining transfers are skipped.
//   - rsp_err clears when the response is taken.
// - FPMUL_SEQ_TIMEOUT_EN undefined: ACCESS waits indefinitely; rsp_err tied to 0;
//   no counter logic.
// TESTING
// - req0 A=0x40000000, B=0x40400000; zero-wait slave model -> APB writes @0x0=0x40000000
//   and @0x4=0x40400000, read @0x8; rsp_valid at T+7; rsp_data=0x40C00000; rsp_id=0.
// - req0 and req1 valid continuously for 4 requests -> grants 0,1,0,1; each rsp_id
//   matches its operands; never two psel transfers overlapping.
// - Slave inserts 3 wait states on each transfer -> rsp_valid at T+16; paddr, pwdata,
//   pwrite stable throughout ACCESS.
// - rsp_ready held 0 for 10 cycles -> rsp_valid, rsp_data, rsp_id stable; reqN_ready
//   stays 0; accept resumes after rsp_ready=1.
// - rst asserted 1 cycle during ACCESS of xfer 1 -> next cycle all outputs 0, busy=0;
//   no rsp_valid for the aborted request; next request completes normally.
// - FPMUL_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> rsp_err=1, rsp_data=0
//   after 16 wait cycles; without the macro busy stays 1 indefinitely.

Source files
------------

// File: rtl/fpmul_apb_sequencer.sv
// APB master sequencer sharing one FP multiplier slave between two round-robin requesters.
// Optional pready timeout enabled by defining FPMUL_SEQ_TIMEOUT_EN.
module fpmul_apb_sequencer #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state_q;
    logic                rr_last_q;
    logic [1:0]          xfer_q;
    logic [DATA_W-1:0]   b_q;
    logic                id_q;

    logic                psel_q;
    logic                penable_q;
    logic                pwrite_q;
    logic [31:0]         paddr_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [DATA_W-1:0]   rsp_data_q;

`ifdef FPMUL_SEQ_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]    tmo_q;
    logic                rsp_err_q;
`endif

    logic                grant_vld;
    logic                grant_id;

    // xfer 0 -> A, 1 -> B, 2 -> product
    function automatic logic [31:0] xfer_addr(input logic [1:0] x);
        return BASE_ADDR + {28'd0, x, 2'b00};
    endfunction

    // Sole valid requester wins; on contention the one not served last wins.
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~rr_last_q;
        end else begin
            grant_id = req1_valid;
        end
    end

    assign req0_ready = (state_q == IDLE) && grant_vld && !grant_id;
    assign req1_ready = (state_q == IDLE) && grant_vld &&  grant_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_last_q   <= 1'b1;
            xfer_q      <= 2'd0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
`ifdef FPMUL_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        // A goes straight into pwdata; only B needs holding for xfer 1
                        b_q       <= grant_id ? req1_b : req0_b;
                        id_q      <= grant_id;
                        rr_last_q <= grant_id;
                        xfer_q    <= 2'd0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= 1'b1;
                        paddr_q   <= xfer_addr(2'd0);
                        pwdata_q  <= grant_id ? req1_a : req0_a;
                        state_q   <= SETUP;
                    end
                end

                SETUP: begin
                    penable_q <= 1'b1;
`ifdef FPMUL_SEQ_TIMEOUT_EN
                    tmo_q     <= '0;
`endif
                    state_q   <= ACCESS;
                end

                ACCESS: begin
                    if (pready) begin
                        if (xfer_q != 2'd2) begin
                            xfer_q    <= xfer_q + 2'd1;
                            penable_q <= 1'b0;
                            paddr_q   <= xfer_addr(xfer_q + 2'd1);
                            pwrite_q  <= (xfer_q == 2'd0);
                            pwdata_q  <= (xfer_q == 2'd0) ? b_q : '0;
                            state_q   <= SETUP;
                        end else begin
                            psel_q      <= 1'b0;
                            penable_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            rsp_id_q    <= id_q;
                            rsp_data_q  <= prdata;
                            state_q     <= RESP;
                        end
                    end
`ifdef FPMUL_SEQ_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        // Abandon the request: skip remaining transfers, flag the error
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef FPMUL_SEQ_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

`ifdef FPMUL_SEQ_TIMEOUT_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
